// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C command arbiter: FSM state, command word layout
// and a counter-width helper.
package i2c_arb_pkg;

  localparam int CMD_W = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] reg_data;
  } i2c_cmd_t;

  // Width of a counter that must reach max_val without wrapping (never 0).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational requester picker: first set request at or after ptr_i
// (wrapping), or lowest index when prio_i is set.
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          prio_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] k;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    k       = '0;
    for (int i = 0; i < N; i++) begin
      sum = prio_i ? (PW+1)'(i) : ({1'b0, ptr_i} + (PW+1)'(i));
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      k = sum[PW-1:0];
      if (!valid_o && req_i[k]) begin
        valid_o    = 1'b1;
        idx_o      = k;
        grant_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C write engine between N_REQ requesters,
// with NACK retry, WAIT timeout and a bus-free gap. Define I2C_ARB_PRIORITY_EN
// for fixed lowest-index-wins priority instead of round-robin.
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 1023,
  parameter int GAP_CYC   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*CMD_W-1:0] i_data,
  output logic [N_REQ-1:0]       o_grant,
  output logic [N_REQ-1:0]       o_done,
  output logic [N_REQ-1:0]       o_err,
  output logic                   o_timeout,
  output logic                   o_busy,
  output logic                   o_eng_start,
  output logic [CMD_W-1:0]       o_eng_data,
  input  logic                   i_eng_fin,
  input  logic                   i_eng_nack,
  output state_e                 o_dbg_state
);

  localparam int PW = $clog2(N_REQ);
  localparam int RW = cnt_w(MAX_RETRY);
  localparam int TW = cnt_w(TIMEOUT);
  localparam int GW = cnt_w(GAP_CYC);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    owner_q, owner_d;
  i2c_cmd_t         data_q, data_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             is_retry_q, is_retry_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic             timeout_q, timeout_d;

  logic [PW-1:0]    ptr;
  logic             prio;
  logic [N_REQ-1:0] pick_grant;
  logic [PW-1:0]    pick_idx;
  logic             pick_valid;

`ifdef I2C_ARB_PRIORITY_EN
  assign ptr  = '0;
  assign prio = 1'b1;
`else
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  assign ptr  = rr_ptr_q;
  assign prio = 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_rst) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == GAP && gap_q == GAP_LAST && !is_retry_q)
      rr_ptr_d = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
  end
`endif

  rr_picker #(.N(N_REQ), .PW(PW)) u_picker (
    .req_i   (i_req),
    .ptr_i   (ptr),
    .prio_i  (prio),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Engine handshake: o_eng_start is a one-cycle launch while o_eng_data is
  // stable; the engine answers with a one-cycle i_eng_fin, i_eng_nack valid
  // only alongside it. fin is honoured only in WAIT.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    data_d     = data_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    is_retry_d = is_retry_q;
    done_d     = '0;
    err_d      = '0;
    timeout_d  = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          owner_d = pick_idx;
          data_d  = i_data[pick_idx*CMD_W +: CMD_W];
          retry_d = '0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        gap_d = '0;
        if (i_eng_fin) begin
          state_d    = GAP;
          is_retry_d = 1'b0;
          if (!i_eng_nack) begin
            done_d = grant_q;
          end else if (retry_q < RETRY_MAX) begin
            retry_d    = retry_q + RW'(1);
            is_retry_d = 1'b1;
          end else begin
            err_d = grant_q;
          end
        end else if (timer_q == TIMER_MAX) begin
          // Expiry loses to a fin arriving in the same cycle (branch above).
          state_d    = GAP;
          is_retry_d = 1'b0;
          err_d      = grant_q;
          timeout_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (is_retry_q) begin
            state_d = LAUNCH;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      data_q     <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      gap_q      <= '0;
      is_retry_q <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      data_q     <= data_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      is_retry_q <= is_retry_d;
      done_q     <= done_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_timeout   = timeout_q;
  assign o_busy      = (state_q != IDLE);
  assign o_eng_start = (state_q == LAUNCH);
  assign o_eng_data  = data_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: a command-level reference model queues expected
// engine launches and done/err pulses; a monitor pops and compares them.
module tb_i2c_cmd_arbiter;
  import i2c_arb_pkg::*;

  localparam int N  = 2;
  localparam int MR = 3;
  localparam int TO = 1023;
  localparam int GC = 4;
  localparam int W  = 3 + N + 24;
  localparam logic [2:0] K_FIRST = 3'd0, K_RETRY = 3'd1, K_NEXT = 3'd2,
                         K_DONE = 3'd3, K_ERR = 3'd4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*24-1:0] data;
  logic [N-1:0]   o_grant, o_done, o_err;
  logic           o_timeout, o_busy, o_eng_start;
  logic [23:0]    o_eng_data;
  logic           eng_fin, eng_nack;
  state_e         o_dbg_state;

  i2c_cmd_arbiter #(.N_REQ(N), .MAX_RETRY(MR), .TIMEOUT(TO), .GAP_CYC(GC)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_data      (data),
    .o_grant     (o_grant),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_timeout   (o_timeout),
    .o_busy      (o_busy),
    .o_eng_start (o_eng_start),
    .o_eng_data  (o_eng_data),
    .i_eng_fin   (eng_fin),
    .i_eng_nack  (eng_nack),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int  eng_dly_q[$];
  bit  eng_nack_q[$];
  int  checks = 0;
  int  errors = 0;
  int  last_fin_cyc = 0;
  int  last_pulse_cyc = 0;
  int  ptr_m = 0;
  bit  exp_timeout = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: one command = attempts until ACK, retry budget or timeout.
  task automatic plan_cmd(input int idx, input logic [23:0] d, input bit first,
                          input logic [7:0] pat, input int dly);
    logic [N-1:0] g;
    logic [2:0]   k;
    int           da;
    g = N'(1) << idx;
    for (int a = 0; a <= MR; a++) begin
      k  = (a == 0) ? (first ? K_FIRST : K_NEXT) : K_RETRY;
      da = (dly < 0) ? int'($urandom_range(1, 12)) : dly;
      exp_q.push_back({k, g, d});
      eng_dly_q.push_back(da);
      eng_nack_q.push_back(pat[a]);
      if (da - 1 > TO) begin
        exp_q.push_back({K_ERR, g, d});
        exp_timeout = 1'b1;
        return;
      end
      if (!pat[a]) begin
        exp_q.push_back({K_DONE, g, d});
        return;
      end
      if (a == MR) begin
        exp_q.push_back({K_ERR, g, d});
        return;
      end
    end
  endtask

  // driver: all requesters in mask assert together and hold until served
  task automatic run_round(input logic [N-1:0] mask, input bit rnd,
                           input logic [7:0] pat, input int dly);
    logic [23:0] cmd[N];
    logic [7:0]  p8;
    int order[$];
    int p;
    int budget;
    for (int k = 0; k < N; k++) cmd[k] = 24'($urandom());
`ifdef I2C_ARB_PRIORITY_EN
    p = 0;
`else
    p = ptr_m;
`endif
    for (int i = 0; i < N; i++)
      if (mask[(p + i) % N]) order.push_back((p + i) % N);
    foreach (order[j]) begin
      p8 = pat;
      if (rnd) for (int a = 0; a < 8; a++) p8[a] = ($urandom_range(0, 2) == 0);
      plan_cmd(order[j], cmd[order[j]], j == 0, p8, rnd ? -1 : dly);
      ptr_m = (order[j] + 1) % N;
    end
    for (int k = 0; k < N; k++) data[k*24 +: 24] = cmd[k];
    req = mask;
    budget = 6000;
    while (req != '0 && budget > 0) begin
      @(negedge clk);
      req = req & ~(o_done | o_err);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL round_budget: req=%b still pending, required all served", req);
      req = '0;
    end
    repeat (GC + 4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("busy_idle", o_busy, 0);
    chk("grant_released", o_grant, 0);
    chk("timeout_flag", o_timeout, exp_timeout);
    exp_q.delete();
    eng_dly_q.delete();
    eng_nack_q.delete();
  endtask

  // engine model: answers each launch from the scripted response queue
  int eng_d;
  bit eng_n;
  initial begin
    eng_fin  = 1'b0;
    eng_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (o_eng_start && !rst) begin
        if (eng_dly_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL engine_script: launch with no scripted response at cycle %0d", cyc);
        end else begin
          eng_d = eng_dly_q.pop_front();
          eng_n = eng_nack_q.pop_front();
          if (eng_d > 0) begin
            repeat (eng_d) @(negedge clk);
            eng_fin      = 1'b1;
            eng_nack     = eng_n;
            last_fin_cyc = cyc;
            @(negedge clk);
            eng_fin  = 1'b0;
            eng_nack = 1'b0;
          end
        end
      end
    end
  end

  // monitor
  logic [W-1:0] mon_e;
  logic [2:0]   mon_k;
  logic [2:0]   mon_exp3;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("done_err_exclusive", |(o_done & o_err), 0);
      chk("grant_onehot0", $onehot0(o_grant), 1);
      if (o_eng_start || |o_done || |o_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: start=%b done=%b err=%b, required none (cycle %0d)",
                   o_eng_start, o_done, o_err, cyc);
        end else begin
          mon_e    = exp_q.pop_front();
          mon_k    = mon_e[W-1 -: 3];
          mon_exp3 = (mon_k <= K_NEXT) ? 3'b100 : ((mon_k == K_DONE) ? 3'b010 : 3'b001);
          chk("event_kind", {o_eng_start, |o_done, |o_err}, mon_exp3);
          chk("event_grant", o_grant, mon_e[24 +: N]);
          if (!o_eng_start) chk("event_owner", o_done | o_err, mon_e[24 +: N]);
          chk("event_data", o_eng_data, mon_e[23:0]);
          if (mon_k == K_RETRY) chk("retry_spacing", cyc - last_fin_cyc, GC + 1);
          if (mon_k == K_NEXT)  chk("next_spacing", cyc - last_pulse_cyc, GC + 1);
          if (|o_done || |o_err) last_pulse_cyc = cyc;
        end
      end
    end
  end

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // stimulus
  int budget;
  bit got;
  logic [23:0] rcmd;
  initial begin
    rst  = 1'b1;
    req  = '0;
    data = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", o_grant, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_start", o_eng_start, 0);
    chk("rst_data", o_eng_data, 0);
    chk("rst_state", o_dbg_state, IDLE);
    rst = 1'b0;
    @(negedge clk);

    // single request: latency, data, done, grant held through the gap
    data[23:0] = 24'h341E00;
    plan_cmd(0, 24'h341E00, 1'b1, 8'h00, 30);
    req = 2'b01;
    @(negedge clk);
    chk("single_start", o_eng_start, 1);
    chk("single_grant", o_grant, 2'b01);
    chk("single_data", o_eng_data, 24'h341E00);
    got = 1'b0;
    budget = 200;
    while (!got && budget > 0) begin
      @(negedge clk);
      got = o_done[0];
      budget--;
    end
    req = '0;
    chk("single_done_seen", got, 1);
    repeat (GC - 1) @(negedge clk);
    chk("single_grant_in_gap", o_grant, 2'b01);
    @(negedge clk);
    chk("single_grant_cleared", o_grant, 0);
    ptr_m = 1;
    repeat (4) @(negedge clk);
    chk("single_queue_drained", exp_q.size(), 0);

    // contention, retry, exhaustion, timeout boundaries
    run_round(2'b11, 1'b0, 8'h00, 5);
    run_round(2'b11, 1'b0, 8'h00, 3);
    run_round(2'b01, 1'b0, 8'b0000_0111, 4);
    run_round(2'b10, 1'b0, 8'b1111_1111, 2);
    run_round(2'b01, 1'b0, 8'h00, TO + 1);
    chk("expiry_tie_no_timeout", o_timeout, 0);
    run_round(2'b10, 1'b0, 8'h00, TO + 3);
    chk("timeout_sticky", o_timeout, 1);
    repeat (20) @(negedge clk);
    chk("timeout_still_sticky", o_timeout, 1);

    // reset while in WAIT, held request regranted afterwards
    rcmd = 24'hA55A01;
    data[23:0] = rcmd;
    exp_q.push_back({K_FIRST, 2'b01, rcmd});
    eng_dly_q.push_back(0);
    eng_nack_q.push_back(1'b0);
    req = 2'b01;
    repeat (6) @(negedge clk);
    chk("pre_reset_state", o_dbg_state, WAIT);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_grant", o_grant, 0);
    chk("mid_rst_start", o_eng_start, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_timeout", o_timeout, 0);
    chk("mid_rst_data", o_eng_data, 0);
    chk("mid_rst_state", o_dbg_state, IDLE);
    chk("mid_rst_queue", exp_q.size(), 0);
    exp_timeout = 1'b0;
    ptr_m = 0;
    rst = 1'b0;
    run_round(2'b01, 1'b0, 8'h00, 6);

    // randomized rounds
    for (int r = 0; r < 30; r++)
      run_round(N'($urandom_range(1, (1 << N) - 1)), 1'b1, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
